// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave APB sequencer: FSM state encoding and err_flags bit positions.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } seq_state_e;

  localparam int unsigned ErrTxUnderflow = 0;
  localparam int unsigned ErrRxOverflow  = 1;
  localparam int unsigned ErrSlverr      = 2;
  localparam int unsigned NumErr         = 3;

endpackage

// File: rtl/spi_slave_sync_fifo.sv
// Single-clock FIFO with flush; push and pop on a full FIFO in the same cycle both take effect.
module spi_slave_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only consumed while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_slave_apb_sequencer.sv
// Turns the decoded SPI command stream into single-beat APB transfers, with a write buffer
// and a read-prefetch FIFO.
module spi_slave_apb_sequencer
  import spi_slave_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH     = 12,
  parameter int unsigned               DATA_WIDTH     = 32,
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned               FIFO_DEPTH     = 2
) (
  input  logic                      sclk,
  input  logic                      sys_rstn,
  input  logic                      ctrl_rd_wr,
  input  logic [ADDR_WIDTH-1:0]     ctrl_addr,
  input  logic                      ctrl_addr_valid,
  input  logic [DATA_WIDTH-1:0]     ctrl_data_rx,
  input  logic                      ctrl_data_rx_valid,
  output logic [DATA_WIDTH-1:0]     ctrl_data_tx,
  input  logic                      ctrl_data_tx_ready,
  input  logic [15:0]               wrap_length,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic                      busy,
  output logic [NumErr-1:0]         err_flags
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WbW   = APB_ADDR_WIDTH + DATA_WIDTH;

  function automatic logic [APB_ADDR_WIDTH-1:0] word_to_paddr(input logic [ADDR_WIDTH-1:0] start,
                                                              input logic [15:0] idx);
    logic [APB_ADDR_WIDTH-1:0] word;
    word = APB_ADDR_WIDTH'(start) + APB_ADDR_WIDTH'(idx);
    return BASE_ADDR + word * APB_ADDR_WIDTH'(Bytes);
  endfunction

  function automatic logic [15:0] next_idx(input logic [15:0] idx, input logic [15:0] wrap);
    logic [15:0] inc;
    inc = idx + 16'd1;
    return ((wrap != 16'd0) && (inc == wrap)) ? 16'd0 : inc;
  endfunction

  seq_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     start_q, start_cur;
  logic [15:0]               idx_q, idx_d, idx_cur;
  logic                      mode_q, mode_cur;
  logic                      cur_wr_q, cur_wr_d;
  logic                      abort_q, abort_d;
  logic [APB_ADDR_WIDTH-1:0] rd_paddr_q, rd_paddr_d, push_paddr;
  logic [NumErr-1:0]         err_q, err_d;

  logic                      complete, pop_wr, push_rd, pop_rd, rx_take, wb_push;
  logic                      wb_full, wb_empty, rd_full, rd_empty;
  logic [CntW-1:0]           wb_count, rd_count, wb_cnt_next, rd_cnt_next;
  logic                      wr_pend, rd_ok, go;
  logic [WbW-1:0]            wb_head;
  logic [DATA_WIDTH-1:0]     rd_head;

  spi_slave_sync_fifo #(.Width(WbW), .Depth(FIFO_DEPTH)) u_wr_buf (
    .clk_i   (sclk),
    .rst_ni  (sys_rstn),
    .flush_i (1'b0),
    .push_i  (wb_push),
    .wdata_i ({push_paddr, ctrl_data_rx}),
    .pop_i   (pop_wr),
    .rdata_o (wb_head),
    .full_o  (wb_full),
    .empty_o (wb_empty),
    .count_o (wb_count)
  );

  spi_slave_sync_fifo #(.Width(DATA_WIDTH), .Depth(FIFO_DEPTH)) u_rd_fifo (
    .clk_i   (sclk),
    .rst_ni  (sys_rstn),
    .flush_i (ctrl_addr_valid),
    .push_i  (push_rd),
    .wdata_i (prdata),
    .pop_i   (pop_rd),
    .rdata_o (rd_head),
    .full_o  (rd_full),
    .empty_o (rd_empty),
    .count_o (rd_count)
  );

  // A new sequence takes effect in the cycle it is strobed.
  always_comb begin
    start_cur  = ctrl_addr_valid ? ctrl_addr : start_q;
    idx_cur    = ctrl_addr_valid ? 16'd0 : idx_q;
    mode_cur   = ctrl_addr_valid ? ctrl_rd_wr : mode_q;
    complete   = (state_q == StAccess) && pready;
    pop_wr     = complete && cur_wr_q;
    push_rd    = complete && !cur_wr_q && !abort_q && !ctrl_addr_valid;
    pop_rd     = ctrl_data_tx_ready && !rd_empty;
    rx_take    = ctrl_data_rx_valid && !mode_cur;
    // Overflow is judged on occupancy alone, independent of a same-cycle drain.
    wb_push    = rx_take && !wb_full;
    push_paddr = word_to_paddr(start_cur, idx_cur);

    idx_d = idx_cur;
    if (rx_take) idx_d = next_idx(idx_cur, wrap_length);
    else if (push_rd) idx_d = next_idx(idx_q, wrap_length);

    err_d = ctrl_addr_valid ? '0 : err_q;
    if (complete && pslverr) err_d[ErrSlverr] = 1'b1;
    if (rx_take && wb_full) err_d[ErrRxOverflow] = 1'b1;
    if (ctrl_data_tx_ready && rd_empty) err_d[ErrTxUnderflow] = 1'b1;
  end

  always_comb begin
    wb_cnt_next = wb_count + CntW'(wb_push) - CntW'(pop_wr);
    rd_cnt_next = ctrl_addr_valid ? '0 : (rd_count + CntW'(push_rd) - CntW'(pop_rd));
    wr_pend     = (wb_cnt_next != '0);
    rd_ok       = mode_cur && (rd_cnt_next < CntW'(FIFO_DEPTH));
    go          = (state_q == StIdle) || complete;

    state_d    = state_q;
    cur_wr_d   = cur_wr_q;
    rd_paddr_d = rd_paddr_q;
    abort_d    = abort_q;

    unique case (state_q)
      StIdle, StAccess: if (go) state_d = (wr_pend || rd_ok) ? StSetup : StIdle;
      StSetup:          state_d = StAccess;
      default:          state_d = StIdle;
    endcase

    // Buffered writes always take precedence over a prefetch read.
    if (go && (wr_pend || rd_ok)) begin
      cur_wr_d = wr_pend;
      if (!wr_pend) rd_paddr_d = word_to_paddr(start_cur, idx_d);
    end

    if (complete) abort_d = 1'b0;
    else if (ctrl_addr_valid && (state_q != StIdle)) abort_d = 1'b1;
  end

  always_ff @(posedge sclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= StIdle;
      start_q    <= '0;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      cur_wr_q   <= 1'b0;
      abort_q    <= 1'b0;
      rd_paddr_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_cur;
      idx_q      <= idx_d;
      mode_q     <= mode_cur;
      cur_wr_q   <= cur_wr_d;
      abort_q    <= abort_d;
      rd_paddr_q <= rd_paddr_d;
      err_q      <= err_d;
    end
  end

  // Write address/data come from the buffer head, which only moves when the transfer completes.
  assign psel         = (state_q != StIdle);
  assign penable      = (state_q == StAccess);
  assign pwrite       = psel && cur_wr_q;
  assign paddr        = !psel ? '0 : (cur_wr_q ? wb_head[WbW-1:DATA_WIDTH] : rd_paddr_q);
  assign pwdata       = pwrite ? wb_head[DATA_WIDTH-1:0] : '0;
  assign ctrl_data_tx = rd_empty ? '0 : rd_head;
  assign busy         = psel || !wb_empty;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_spi_slave_apb_sequencer.sv
// Directed bench for spi_slave_apb_sequencer: a cycle table plus hand-written corner sequences.
module tb_spi_slave_apb_sequencer;

  localparam logic [31:0] Mask = 32'hA5A5_0000;

  logic        sclk = 1'b0;
  logic        sys_rstn;
  logic        rw, av, rxv, txr, rdy, serr, auto_rd;
  logic [11:0] addr;
  logic [31:0] rxd, prdata_tbl, prdata, tx, paddr, pwdata;
  logic [15:0] wrap;
  logic        pwrite, psel, penable, busy;
  logic [2:0]  err_flags;

  int n_vec = 0;
  int n_bad = 0;

  always #5 sclk = ~sclk;

  // Auto mode returns data derived from the address so popped words identify their source.
  assign prdata = auto_rd ? (paddr ^ Mask) : prdata_tbl;

  spi_slave_apb_sequencer #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .APB_ADDR_WIDTH(32),
    .BASE_ADDR(32'h1000), .FIFO_DEPTH(2)
  ) dut (
    .sclk(sclk), .sys_rstn(sys_rstn), .ctrl_rd_wr(rw), .ctrl_addr(addr),
    .ctrl_addr_valid(av), .ctrl_data_rx(rxd), .ctrl_data_rx_valid(rxv),
    .ctrl_data_tx(tx), .ctrl_data_tx_ready(txr), .wrap_length(wrap),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(rdy), .pslverr(serr), .busy(busy), .err_flags(err_flags)
  );

  typedef struct packed {
    logic        av, rw;
    logic [11:0] addr;
    logic        rxv;
    logic [31:0] rxd;
    logic        txr, rdy, serr;
    logic [31:0] prd;
    logic        e_psel, e_pen;
    logic [31:0] e_paddr;
    logic        e_pwrite;
    logic [31:0] e_pwdata, e_tx;
    logic        e_busy;
    logic [2:0]  e_err;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic r, input logic [11:0] ad,
                              input logic xv, input logic [31:0] xd, input logic tr,
                              input logic rd, input logic se, input logic [31:0] pd,
                              input logic ps, input logic pe, input logic [31:0] pa,
                              input logic pw, input logic [31:0] wd, input logic [31:0] t,
                              input logic b, input logic [2:0] e);
    vec_t v;
    v = '{av: a, rw: r, addr: ad, rxv: xv, rxd: xd, txr: tr, rdy: rd, serr: se, prd: pd,
          e_psel: ps, e_pen: pe, e_paddr: pa, e_pwrite: pw, e_pwdata: wd, e_tx: t,
          e_busy: b, e_err: e};
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
  endtask

  task automatic wait_access(input string name);
    int i;
    i = 0;
    while (!(psel && penable) && i < 50) begin
      tick();
      i++;
    end
    if (!(psel && penable)) check({name, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 100) begin
      tick();
      i++;
    end
    if (busy) check({name, "_timeout"}, 128'd1, 128'd0);
  endtask

  vec_t vecs[$];
  logic [31:0] wexp[6];
  int pops;

  initial begin
    sys_rstn = 1'b0; av = 0; rw = 0; addr = '0; rxv = 0; rxd = '0; txr = 0; rdy = 1;
    serr = 0; auto_rd = 0; prdata_tbl = '0; wrap = '0;

    // Read prefetch from word 3, pops, underflow, abort, then a write burst with overflow.
    vecs.push_back(mk(1,1,12'd3,0,0,0,1,0,0,              0,0,32'h0,0,0,0,0,3'b000));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,32'h1111_0001,      1,0,32'h100C,0,0,0,1,3'b000));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,32'h1111_0001,      1,1,32'h100C,0,0,0,1,3'b000));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,32'h2222_0002,      1,0,32'h1010,0,0,32'h1111_0001,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,32'h2222_0002,      1,1,32'h1010,0,0,32'h1111_0001,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,                  0,0,32'h0,0,0,32'h1111_0001,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,                  0,0,32'h0,0,0,32'h1111_0001,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,1,0,0,                  0,0,32'h0,0,0,32'h1111_0001,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,1,0,0,                  1,0,32'h1014,0,0,32'h2222_0002,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,32'h3333_0003,      1,1,32'h1014,0,0,0,1,3'b000));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,32'h3333_0003,      1,1,32'h1014,0,0,0,1,3'b000));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,32'h3333_0003,      1,1,32'h1014,0,0,0,1,3'b001));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,32'h4444_0004,      1,0,32'h1018,0,0,32'h3333_0003,1,1));
    vecs.push_back(mk(1,0,12'd5,0,0,0,1,0,32'h4444_0004,  1,1,32'h1018,0,0,32'h3333_0003,1,1));
    vecs.push_back(mk(0,0,0,1,32'hDEAD_0001,0,1,0,0,      0,0,32'h0,0,0,0,0,3'b000));
    vecs.push_back(mk(0,0,0,1,32'hDEAD_0002,0,1,0,0,      1,0,32'h1014,1,32'hDEAD_0001,0,1,0));
    vecs.push_back(mk(0,0,0,1,32'hDEAD_0003,0,1,0,0,      1,1,32'h1014,1,32'hDEAD_0001,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,1,0,                  1,0,32'h1018,1,32'hDEAD_0002,0,1,2));
    vecs.push_back(mk(0,0,0,0,0,0,1,1,0,                  1,1,32'h1018,1,32'hDEAD_0002,0,1,2));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,                  0,0,32'h0,0,0,0,0,3'b110));

    repeat (3) tick();
    sys_rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      av = vecs[i].av; rw = vecs[i].rw; addr = vecs[i].addr; rxv = vecs[i].rxv;
      rxd = vecs[i].rxd; txr = vecs[i].txr; rdy = vecs[i].rdy; serr = vecs[i].serr;
      prdata_tbl = vecs[i].prd;
      #1;
      check($sformatf("vec%0d", i),
            {25'd0, psel, penable, paddr, pwrite, pwdata, tx, busy, err_flags},
            {25'd0, vecs[i].e_psel, vecs[i].e_pen, vecs[i].e_paddr, vecs[i].e_pwrite,
             vecs[i].e_pwdata, vecs[i].e_tx, vecs[i].e_busy, vecs[i].e_err});
    end

    // Slave error on a lone write: flags cleared by the new sequence, only slverr remains.
    tick(); av = 1; rw = 0; addr = 12'd0; rxv = 0; txr = 0; rdy = 1; serr = 1;
    tick(); av = 0; rxv = 1; rxd = 32'h55;
    tick(); rxv = 0;
    wait_idle("slverr_write");
    check("slverr_write_flags", {125'd0, err_flags}, {125'd0, 3'b100});
    serr = 0;

    // Stalled write: everything on the bus holds while pready is low.
    rdy = 0;
    tick(); av = 1; rw = 0; addr = 12'h10;
    tick(); av = 0; rxv = 1; rxd = 32'h77;
    tick(); rxv = 0;
    wait_access("stall");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_hold%0d", k),
            {60'd0, psel, penable, paddr, pwrite, pwdata, busy},
            {60'd0, 1'b1, 1'b1, 32'h1040, 1'b1, 32'h77, 1'b1});
      tick();
    end
    rdy = 1;
    wait_idle("stall_drain");

    // Wrap window of 4 starting at word 2.
    for (int k = 0; k < 6; k++) wexp[k] = (32'h1000 + 32'(2 + (k % 4)) * 4) ^ Mask;
    wexp[4] = (32'h1000 + 32'd2 * 4) ^ Mask;
    wexp[5] = (32'h1000 + 32'd3 * 4) ^ Mask;
    auto_rd = 1; wrap = 16'd4;
    tick(); av = 1; rw = 1; addr = 12'd2;
    tick(); av = 0;
    pops = 0;
    for (int c = 0; c < 200 && pops < 6; c++) begin
      txr = 0;
      if (tx != 32'h0) begin
        check($sformatf("wrap_pop%0d", pops), {96'd0, tx}, {96'd0, wexp[pops]});
        txr = 1;
        pops++;
      end
      tick();
    end
    txr = 0; wrap = 16'd0;
    if (pops < 6) check("wrap_pops_timeout", 128'(pops), 128'd6);
    repeat (6) tick();
    wait_idle("wrap_settle");

    // New sequence while a read is stalled in ACCESS: its data must be dropped.
    rdy = 0; av = 1; rw = 1; addr = 12'd8;
    tick(); av = 0;
    wait_access("abort");
    check("abort_old_addr", {96'd0, paddr}, {96'd0, 32'h1020});
    av = 1; addr = 12'h20;
    tick(); av = 0; rdy = 1;
    tick();
    check("abort_new_setup", {60'd0, psel, penable, paddr, tx},
          {60'd0, 1'b1, 1'b0, 32'h1080, 32'h0});

    // Asynchronous reset in the middle of a stalled ACCESS.
    rdy = 0;
    wait_access("reset");
    sys_rstn = 1'b0;
    #1;
    check("reset_mid_access",
          {25'd0, psel, penable, paddr, pwrite, pwdata, tx, busy, err_flags}, 128'd0);
    tick();
    sys_rstn = 1'b1; auto_rd = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
